// File: rtl/dmac_pkg.sv
// Shared definitions for the DMA controller: AHB transfer/size encodings,
// the channel controller state type and a beat-size clamp helper.
package dmac_pkg;

    localparam int unsigned HTRANS_W = 2;
    localparam int unsigned HSIZE_W  = 2;

    typedef enum logic [HTRANS_W-1:0] {
        HTRANS_IDLE    = 2'b00,
        HTRANS_BUSY    = 2'b01,
        HTRANS_NON_SEQ = 2'b10,
        HTRANS_SEQ     = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_TURN  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [HSIZE_W-1:0] HSIZE_BYTE = 2'd0;
    localparam logic [HSIZE_W-1:0] HSIZE_HALF = 2'd1;
    localparam logic [HSIZE_W-1:0] HSIZE_WORD = 2'd2;

    // Encoding 3 is reserved; it behaves as a word access.
    function automatic logic [HSIZE_W-1:0] hsize_clamp(input logic [HSIZE_W-1:0] h);
        return (h == 2'd3) ? HSIZE_WORD : h;
    endfunction

endpackage

// File: rtl/dmac_addr_gen.sv
// Load/increment address register.
// Ports: clk, rst_n (async active-low), en (update), sel (1=load cfg, 0=add inc),
//        cfg (start address), inc (step), addr (registered address).
module dmac_addr_gen #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sel,
    input  logic [ADDR_W-1:0] cfg,
    input  logic [ADDR_W-1:0] inc,
    output logic [ADDR_W-1:0] addr
);

    // Increment wraps modulo 2**ADDR_W with no carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (en) begin
            addr <= sel ? cfg : addr + inc;
        end
    end

endmodule

// File: rtl/dmac_channel_dp.sv
// Per-channel DMA datapath: source/destination address generators, remaining
// transfer counter, burst-length register and beat counter, plus the status
// flags consumed by the channel controller.
// Ports: clk, rst (async active-low); *_cfg programmed values; s/d/t/b/h_sel
//        operand selects; s_en/d_en/ts_en/burst_en/count_en register enables;
//        HAddr/HSize AHB address and size; bsz/tsz/tslb flags; beat_cnt.
module dmac_channel_dp
    import dmac_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned BS_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src_addr_cfg,
    input  logic [ADDR_W-1:0] dst_addr_cfg,
    input  logic [TS_W-1:0]   trans_size_cfg,
    input  logic [BS_W-1:0]   burst_size_cfg,
    input  logic [1:0]        hsize_cfg,
    input  logic              s_sel,
    input  logic              d_sel,
    input  logic              t_sel,
    input  logic              b_sel,
    input  logic              h_sel,
    input  logic              s_en,
    input  logic              d_en,
    input  logic              ts_en,
    input  logic              burst_en,
    input  logic              count_en,
    output logic [ADDR_W-1:0] HAddr,
    output logic [2:0]        HSize,
    output logic              bsz,
    output logic              tsz,
    output logic              tslb,
    output logic [BS_W-1:0]   beat_cnt
);

    logic [1:0]        hsize_eff;
    logic [ADDR_W-1:0] inc;
    logic [BS_W-1:0]   bs_eff;
    logic [TS_W-1:0]   rem_src;
    logic [TS_W-1:0]   burst_len_ext;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [TS_W-1:0]   ts_rem;
    logic [BS_W-1:0]   burst_len;

    assign hsize_eff     = hsize_clamp(hsize_cfg);
    assign inc           = ADDR_W'(1) << hsize_eff;
    assign bs_eff        = (burst_size_cfg == '0) ? BS_W'(1) : burst_size_cfg;
    // Remaining size seen by the controller: the freshly programmed size while loading.
    assign rem_src       = t_sel ? trans_size_cfg : ts_rem;
    assign burst_len_ext = TS_W'(burst_len);

    dmac_addr_gen #(.ADDR_W(ADDR_W)) u_src_gen (
        .clk   (clk),
        .rst_n (rst),
        .en    (s_en),
        .sel   (s_sel),
        .cfg   (src_addr_cfg),
        .inc   (inc),
        .addr  (src_addr)
    );

    dmac_addr_gen #(.ADDR_W(ADDR_W)) u_dst_gen (
        .clk   (clk),
        .rst_n (rst),
        .en    (d_en),
        .sel   (d_sel),
        .cfg   (dst_addr_cfg),
        .inc   (inc),
        .addr  (dst_addr)
    );

    // Remaining transfer size: one burst retired per decrement, floored at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_rem <= '0;
        end else if (ts_en) begin
            if (t_sel) begin
                ts_rem <= trans_size_cfg;
            end else if (ts_rem > burst_len_ext) begin
                ts_rem <= ts_rem - burst_len_ext;
            end else begin
                ts_rem <= '0;
            end
        end
    end

    // Burst length: full burst, or the short tail when fewer beats remain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_len <= '0;
        end else if (burst_en) begin
            burst_len <= b_sel ? BS_W'(rem_src) : bs_eff;
        end
    end

    // Beat counter: cleared on every burst-length update, wraps after the last beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
        end else if (burst_en) begin
            beat_cnt <= '0;
        end else if (count_en) begin
            beat_cnt <= bsz ? '0 : beat_cnt + BS_W'(1);
        end
    end

    assign bsz   = (burst_len != '0) && (beat_cnt == burst_len - BS_W'(1));
    assign tsz   = (ts_rem == '0);
    assign tslb  = (rem_src != '0) && (rem_src < TS_W'(bs_eff));
    assign HAddr = h_sel ? dst_addr : src_addr;
    assign HSize = {1'b0, hsize_eff};

endmodule
